// File: rtl/ring_flow_pkg.sv
// Shared types and default sizing for the ring-buffer flow monitor.
package ring_flow_pkg;

   localparam int DEF_NUM_CH    = 2;
   localparam int DEF_PTR_WIDTH = 16;

   typedef logic [DEF_PTR_WIDTH-1:0] ptr_t;
   typedef logic [DEF_PTR_WIDTH:0]   lvl_t;

   typedef enum logic [1:0] {IDLE, RUN, FAULT} ch_state_e;

endpackage

// File: rtl/ring_flow_channel.sv
// One ring channel: pointer/parity capture, level and enable generation, sticky faults.
// RING_FLOW_WATERMARK_EN adds hysteresis watermarks on the producer/consumer enables.
module ring_flow_channel
   import ring_flow_pkg::*;
#(
   parameter int PTR_WIDTH = DEF_PTR_WIDTH
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic                 enable,
   input  logic                 clr,
   input  logic [PTR_WIDTH-1:0] cfg_size,
   input  logic [PTR_WIDTH-1:0] prod_ptr,
   input  logic [PTR_WIDTH-1:0] cons_ptr,
`ifdef RING_FLOW_WATERMARK_EN
   input  logic [PTR_WIDTH:0]   cfg_hi_wm,
   input  logic [PTR_WIDTH:0]   cfg_lo_wm,
`endif
   output logic [PTR_WIDTH:0]   level,
   output logic                 prod_en,
   output logic                 cons_en,
   output logic                 overflow,
   output logic                 underflow,
   output logic                 stopped
);

   ch_state_e              state_reg;
   logic [PTR_WIDTH-1:0]   prod_reg, cons_reg;
   logic                   prod_par_reg, cons_par_reg;
   logic [PTR_WIDTH:0]     level_reg;
   logic                   prod_en_reg, cons_en_reg, ovf_reg, udf_reg, stopped_reg;

   logic [PTR_WIDTH:0]     size_ext, prod_ext, cons_ext, lvl_calc;
   logic                   par_eq, range_err, ovf_det, udf_det;
   logic                   prod_en_calc, cons_en_calc;

   // Level and faults are evaluated on the captured pointers, giving one extra edge of latency.
   assign size_ext  = {1'b0, cfg_size};
   assign prod_ext  = {1'b0, prod_reg};
   assign cons_ext  = {1'b0, cons_reg};
   assign par_eq    = (prod_par_reg == cons_par_reg);
   assign lvl_calc  = par_eq ? (prod_ext - cons_ext) : (size_ext - cons_ext + prod_ext);
   assign range_err = (prod_reg >= cfg_size) || (cons_reg >= cfg_size);
   assign ovf_det   = range_err || (!par_eq && (prod_reg > cons_reg));
   assign udf_det   = !range_err && par_eq && (cons_reg > prod_reg);

`ifdef RING_FLOW_WATERMARK_EN
   logic fall_par_reg;

   always_comb begin
      prod_en_calc = prod_en_reg ? (lvl_calc < cfg_hi_wm) : (lvl_calc <= cfg_lo_wm);
      cons_en_calc = (lvl_calc != '0) &&
                     ((lvl_calc >= cfg_lo_wm) || (prod_par_reg != fall_par_reg));
   end

   // Producer parity remembered at the last consumer-enable fall: a toggle means fresh data.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
         fall_par_reg <= 1'b0;
      else if (state_reg == RUN && clr)
         fall_par_reg <= 1'b0;
      else if (state_reg == RUN && cons_en_reg && !cons_en_calc)
         fall_par_reg <= prod_par_reg;
   end
`else
   assign prod_en_calc = (lvl_calc < size_ext);
   assign cons_en_calc = (lvl_calc != '0);
`endif

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_reg    <= IDLE;
         prod_reg     <= '0;
         cons_reg     <= '0;
         prod_par_reg <= 1'b0;
         cons_par_reg <= 1'b0;
         level_reg    <= '0;
         prod_en_reg  <= 1'b0;
         cons_en_reg  <= 1'b0;
         ovf_reg      <= 1'b0;
         udf_reg      <= 1'b0;
         stopped_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               level_reg   <= '0;
               prod_en_reg <= 1'b0;
               cons_en_reg <= 1'b0;
               if (clr) begin
                  ovf_reg <= 1'b0;
                  udf_reg <= 1'b0;
               end else if (enable && cfg_size != '0) begin
                  state_reg    <= RUN;
                  prod_reg     <= prod_ptr;
                  cons_reg     <= cons_ptr;
                  prod_par_reg <= 1'b0;
                  cons_par_reg <= 1'b0;
               end
            end
            RUN: begin
               if (clr) begin
                  prod_reg     <= prod_ptr;
                  cons_reg     <= cons_ptr;
                  prod_par_reg <= 1'b0;
                  cons_par_reg <= 1'b0;
                  ovf_reg      <= 1'b0;
                  udf_reg      <= 1'b0;
                  level_reg    <= '0;
                  prod_en_reg  <= 1'b0;
                  cons_en_reg  <= 1'b0;
               end else if (!enable) begin
                  state_reg   <= IDLE;
                  level_reg   <= '0;
                  prod_en_reg <= 1'b0;
                  cons_en_reg <= 1'b0;
               end else if (ovf_det || udf_det) begin
                  // Pointers, parities and level freeze at the snapshot that faulted.
                  state_reg   <= FAULT;
                  stopped_reg <= 1'b1;
                  ovf_reg     <= ovf_reg | ovf_det;
                  udf_reg     <= udf_reg | udf_det;
                  prod_en_reg <= 1'b0;
                  cons_en_reg <= 1'b0;
               end else begin
                  level_reg    <= lvl_calc;
                  prod_en_reg  <= prod_en_calc;
                  cons_en_reg  <= cons_en_calc;
                  prod_reg     <= prod_ptr;
                  cons_reg     <= cons_ptr;
                  prod_par_reg <= prod_par_reg ^ (prod_ptr < prod_reg);
                  cons_par_reg <= cons_par_reg ^ (cons_ptr < cons_reg);
               end
            end
            FAULT: begin
               if (clr) begin
                  state_reg   <= IDLE;
                  stopped_reg <= 1'b0;
                  ovf_reg     <= 1'b0;
                  udf_reg     <= 1'b0;
                  level_reg   <= '0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign level     = level_reg;
   assign prod_en   = prod_en_reg;
   assign cons_en   = cons_en_reg;
   assign overflow  = ovf_reg;
   assign underflow = udf_reg;
   assign stopped   = stopped_reg;

endmodule

// File: rtl/ring_flow_monitor.sv
// Multi-channel DMA ring pointer monitor; one ring_flow_channel per ring plus a global fault flag.
// RING_FLOW_WATERMARK_EN adds per-channel cfg_hi_wm / cfg_lo_wm ports.
module ring_flow_monitor
   import ring_flow_pkg::*;
#(
   parameter int NUM_CH    = DEF_NUM_CH,
   parameter int PTR_WIDTH = DEF_PTR_WIDTH
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic                          enable,
   input  logic [NUM_CH-1:0]             clr,
   input  logic [NUM_CH*PTR_WIDTH-1:0]   cfg_size,
   input  logic [NUM_CH*PTR_WIDTH-1:0]   prod_ptr,
   input  logic [NUM_CH*PTR_WIDTH-1:0]   cons_ptr,
`ifdef RING_FLOW_WATERMARK_EN
   input  logic [NUM_CH*(PTR_WIDTH+1)-1:0] cfg_hi_wm,
   input  logic [NUM_CH*(PTR_WIDTH+1)-1:0] cfg_lo_wm,
`endif
   output logic [NUM_CH*(PTR_WIDTH+1)-1:0] level,
   output logic [NUM_CH-1:0]             prod_en,
   output logic [NUM_CH-1:0]             cons_en,
   output logic [NUM_CH-1:0]             overflow,
   output logic [NUM_CH-1:0]             underflow,
   output logic [NUM_CH-1:0]             stopped,
   output logic                          fault_any
);

   localparam int LW = PTR_WIDTH + 1;

   logic fault_any_reg;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         ring_flow_channel #(
            .PTR_WIDTH (PTR_WIDTH)
         ) u_ch (
            .aclk      (aclk),
            .aresetn   (aresetn),
            .enable    (enable),
            .clr       (clr[gi]),
            .cfg_size  (cfg_size[gi*PTR_WIDTH +: PTR_WIDTH]),
            .prod_ptr  (prod_ptr[gi*PTR_WIDTH +: PTR_WIDTH]),
            .cons_ptr  (cons_ptr[gi*PTR_WIDTH +: PTR_WIDTH]),
`ifdef RING_FLOW_WATERMARK_EN
            .cfg_hi_wm (cfg_hi_wm[gi*LW +: LW]),
            .cfg_lo_wm (cfg_lo_wm[gi*LW +: LW]),
`endif
            .level     (level[gi*LW +: LW]),
            .prod_en   (prod_en[gi]),
            .cons_en   (cons_en[gi]),
            .overflow  (overflow[gi]),
            .underflow (underflow[gi]),
            .stopped   (stopped[gi])
         );
      end
   endgenerate

   // Registered off the sticky flags, so it trails them by one edge.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
         fault_any_reg <= 1'b0;
      else
         fault_any_reg <= |(overflow | underflow);
   end

   assign fault_any = fault_any_reg;

endmodule
